// File: rtl/decode_stage_hazard_if.sv
// ID stage bus: decode inputs from fetch/writeback/EX and the registered ID/EX entry.
// master drives the decode inputs, slave is the decode stage itself.
interface decode_stage_hazard_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           instruction;
    logic                  instrValid;
    logic                  stall;
    logic                  flush;
    logic                  regWrite;
    logic [4:0]            writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  exMemRead;
    logic [4:0]            exRt;
    logic                  loadUseHazard;
    logic                  outValid;
    logic [5:0]            opCode;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] readDataNumberOne;
    logic [DATA_WIDTH-1:0] readDataNumberTwo;
    logic [DATA_WIDTH-1:0] extendedImmediate;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;

    modport master (
        output instruction, instrValid, stall, flush, regWrite, writeReg, writeData,
               exMemRead, exRt,
        input  loadUseHazard, outValid, opCode, funct, readDataNumberOne,
               readDataNumberTwo, extendedImmediate, rs, rt, rd
    );

    modport slave (
        input  instruction, instrValid, stall, flush, regWrite, writeReg, writeData,
               exMemRead, exRt,
        output loadUseHazard, outValid, opCode, funct, readDataNumberOne,
               readDataNumberTwo, extendedImmediate, rs, rt, rd
    );
endinterface

// File: rtl/decode_stage_hazard.sv
// MIPS decode stage: field split, bypassed register file read, immediate extension,
// load-use hazard detection and a valid-tagged ID/EX register with stall/flush bubbles.
module decode_stage_hazard #(
    parameter int DATA_WIDTH             = 32,
    parameter int ZERO_REG               = 1,
    parameter int CLEAR_REGFILE_ON_RESET = 1
) (
    input  logic           clock,
    input  logic           reset,
    decode_stage_hazard_if.slave bus
);

    logic [DATA_WIDTH-1:0] regfile_r [32];

    logic [5:0]            opcode_s;
    logic [5:0]            funct_s;
    logic [4:0]            rs_s;
    logic [4:0]            rt_s;
    logic [4:0]            rd_s;
    logic [15:0]           imm_s;
    logic                  write_en_s;
    logic [DATA_WIDTH-1:0] read_one_s;
    logic [DATA_WIDTH-1:0] read_two_s;
    logic [DATA_WIDTH-1:0] imm_ext_s;
    logic                  hazard_s;
    logic                  unused_shamt_s;

    logic                  out_valid_r;
    logic [5:0]            opcode_r;
    logic [5:0]            funct_r;
    logic [DATA_WIDTH-1:0] read_one_r;
    logic [DATA_WIDTH-1:0] read_two_r;
    logic [DATA_WIDTH-1:0] imm_ext_r;
    logic [4:0]            rs_r;
    logic [4:0]            rt_r;
    logic [4:0]            rd_r;

    assign opcode_s       = bus.instruction[31:26];
    assign rs_s           = bus.instruction[25:21];
    assign rt_s           = bus.instruction[20:16];
    assign rd_s           = bus.instruction[15:11];
    assign funct_s        = bus.instruction[5:0];
    assign imm_s          = bus.instruction[15:0];
    assign unused_shamt_s = ^bus.instruction[10:6];

    assign write_en_s = bus.regWrite && !((ZERO_REG != 0) && (bus.writeReg == 5'd0));

    // Register file storage; clearing on reset is optional so it can map onto RAM.
    always_ff @(posedge clock) begin
        if (reset && (CLEAR_REGFILE_ON_RESET != 0)) begin
            for (int i = 0; i < 32; i++) begin
                regfile_r[i] <= '0;
            end
        end else if (write_en_s) begin
            regfile_r[bus.writeReg] <= bus.writeData;
        end
    end

    // Port one read: hardwired zero beats the writeback bypass, which beats storage.
    always_comb begin
        read_one_s = '0;
        if ((ZERO_REG != 0) && (rs_s == 5'd0)) begin
            read_one_s = '0;
        end else if (bus.regWrite && (bus.writeReg == rs_s)) begin
            read_one_s = bus.writeData;
        end else begin
            read_one_s = regfile_r[rs_s];
        end
    end

    // Port two read, same priority as port one.
    always_comb begin
        read_two_s = '0;
        if ((ZERO_REG != 0) && (rt_s == 5'd0)) begin
            read_two_s = '0;
        end else if (bus.regWrite && (bus.writeReg == rt_s)) begin
            read_two_s = bus.writeData;
        end else begin
            read_two_s = regfile_r[rt_s];
        end
    end

    // Immediate extension: logical ops zero-extend, LUI shifts up, everything else sign-extends.
    always_comb begin
        imm_ext_s = '0;
        case (opcode_s)
            6'h0C, 6'h0D, 6'h0E: begin
                imm_ext_s        = '0;
                imm_ext_s[15:0]  = imm_s;
            end
            6'h0F: begin
                imm_ext_s        = '0;
                imm_ext_s[31:16] = imm_s;
            end
            default: begin
                imm_ext_s = {{(DATA_WIDTH-16){imm_s[15]}}, imm_s};
            end
        endcase
    end

    assign hazard_s = bus.instrValid && bus.exMemRead && (bus.exRt != 5'd0)
                      && ((bus.exRt == rs_s) || (bus.exRt == rt_s));

    // ID/EX register: reset, then flush, then stall hold, then hazard bubble, then load.
    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            out_valid_r <= 1'b0;
            opcode_r    <= 6'd0;
            funct_r     <= 6'd0;
            read_one_r  <= '0;
            read_two_r  <= '0;
            imm_ext_r   <= '0;
            rs_r        <= 5'd0;
            rt_r        <= 5'd0;
            rd_r        <= 5'd0;
        end else if (bus.stall) begin
            out_valid_r <= out_valid_r;
        end else if (hazard_s) begin
            out_valid_r <= 1'b0;
            opcode_r    <= 6'd0;
            funct_r     <= 6'd0;
            read_one_r  <= '0;
            read_two_r  <= '0;
            imm_ext_r   <= '0;
            rs_r        <= 5'd0;
            rt_r        <= 5'd0;
            rd_r        <= 5'd0;
        end else begin
            out_valid_r <= bus.instrValid;
            opcode_r    <= opcode_s;
            funct_r     <= funct_s;
            read_one_r  <= read_one_s;
            read_two_r  <= read_two_s;
            imm_ext_r   <= imm_ext_s;
            rs_r        <= rs_s;
            rt_r        <= rt_s;
            rd_r        <= rd_s;
        end
    end

    assign bus.loadUseHazard     = hazard_s;
    assign bus.outValid          = out_valid_r;
    assign bus.opCode            = opcode_r;
    assign bus.funct             = funct_r;
    assign bus.readDataNumberOne = read_one_r;
    assign bus.readDataNumberTwo = read_two_r;
    assign bus.extendedImmediate = imm_ext_r;
    assign bus.rs                = rs_r;
    assign bus.rt                = rt_r;
    assign bus.rd                = rd_r;

endmodule
